i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
- I2C target (responder) for single-master write traffic, e.g. the codec-initialisation master.
- Behaves like the WM8731 control port: 7-bit device address, then 16-bit frames of {reg_addr[6:0], data[8:0]}.
- Used as the codec register model in benches, and synthesisable for loopback checks on the board.
- Samples the open-drain bus with the system clock and drives ACK by pulling SDA low.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (write byte 0x34).
- SYNC_STAGES, 2, synchroniser depth on i_sclk/i_sdat (min 2).
- MAX_REG, 7'h0F, highest legal register address (used only with the optional feature).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sclk  in  1  SCL line as resolved on the bus.
- i_sdat  in  1  SDA line as resolved on the bus (wired-AND of master drive and ~o_sdat_pull).
- o_sdat_pull  out  1  1 = pull SDA low (ACK); 0 = release.
- o_valid  out  1  one-cycle pulse: frame accepted.
- o_reg_addr  out  7  register address of the last accepted frame.
- o_reg_data  out  9  register data of the last accepted frame.
- o_busy  out  1  high between START and STOP while addressed.
- o_err  out  1  one-cycle pulse on protocol/frame error.

Behaviour:
- Reset, asynchronous, active-low:
  - All outputs go to 0 and the state goes to IDLE.
  - Shift register, bit counter and byte counter are cleared.
  - Synchroniser flops reset to 1 (idle bus).
- Input front end:
  - i_sclk and i_sdat pass through SYNC_STAGES flops, then one edge-detect register.
  - Internal event latency is SYNC_STAGES+1 cycles.
  - Requires an SCL half-period of at least SYNC_STAGES+3 clocks.
- Bus events, judged on synchronised signals:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising and shifted in MSB first.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR, after 8 bits:
    - addr[7:1]==DEV_ADDR and R/W==0 -> ADDR_ACK.
    - Otherwise -> IGNORE with no ACK; o_err pulses only if the address matched but R/W==1.
  - ADDR_ACK: assert o_sdat_pull on the next SCL falling edge, hold through one SCL high phase, release on the following SCL falling edge, then -> DATA.
  - DATA, after 8 bits -> DATA_ACK.
    - Byte 0 loads {reg_addr[6:0], data[8]}.
    - Byte 1 loads data[7:0].
    - o_valid pulses in the cycle byte 1's 8th bit is sampled; o_reg_addr/o_reg_data update in that same cycle and hold until the next accepted frame.
  - DATA_ACK: ACK timing identical to ADDR_ACK. Returns to DATA with the byte counter incremented.
  - Byte index >= 2: no ACK, o_err pulses, -> IGNORE.
  - IGNORE: wait for START or STOP; no pull.
- Repeated START in any state -> ADDR: partial frame discarded, no o_err.
- STOP in any state -> IDLE and o_sdat_pull released immediately.
  - STOP with byte counter ==1 (half frame) pulses o_err.
- o_busy = 1 in ADDR_ACK, DATA and DATA_ACK.
- Simultaneous START/STOP flag with a bit sample: the bus event wins.

Optional Feature:
- Macro: I2C_TGT_REG_CHECK_EN.
- Defined: if the reg_addr in byte 0 exceeds MAX_REG, byte 0 is NACKed, o_err pulses, -> IGNORE, and no o_valid is produced.
- Undefined: every reg_addr is accepted and MAX_REG is unused.

Decomposition:
- Package i2c_tgt_pkg holds:
  - state enum (IDLE..IGNORE);
  - constant for the 16-bit frame byte count (2);
  - WM8731 default DEV_ADDR constant.
- Sub-module i2c_bus_sync: synchroniser, edge detect, start/stop/rise/fall strobes.

Test Plan:
- Master sends 0x34, 0x04, 0x15, STOP -> ACKs on all three bytes; o_valid once; o_reg_addr=0x02, o_reg_data=0x015; o_err never.
- Master sends 0x36 -> no ACK (SDA high in 9th clock); IGNORE until STOP; no o_valid, no o_err.
- Master sends 0x35 (read) -> NACK; o_err one pulse; no o_valid.
- Master sends 0x34, 0x1E, 0x00, 0xAA -> o_valid with reg 0x0F, data 0x000; 4th byte NACK; o_err one pulse.
- Master sends 0x34, 0x04, then STOP -> o_err one pulse, no o_valid; o_reg_* unchanged.
  - Repeat with i_rst_n pulsed low mid-byte -> all outputs 0 immediately; next full frame is accepted normally.
- With I2C_TGT_REG_CHECK_EN defined: 0x34, 0x22 (reg 0x11) -> byte NACKed, o_err one pulse, no o_valid.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C write-only register target.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2c_tgt_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      DATA     = 3'd3,
      DATA_ACK = 3'd4,
      IGNORE   = 3'd5
   } state_t;

   // A WM8731 control word is two bytes: {reg_addr[6:0], data[8]} then data[7:0].
   localparam logic [1:0] FRAME_BYTES     = 2'd2;
   localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and flags START, STOP and SCL rise/fall.
// Latency: SYNC_STAGES flops plus one edge-detect register to each strobe.
// Backpressure: none; strobes are single-cycle and must be consumed at once.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic sdat,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_d;
   logic                   sda_d;

   // Flops reset to 1 so an idle bus produces no spurious edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclk};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sdat};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign sda      = sda_s;
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   // SCL must be high in both samples so an SDA move next to an SCL edge is not a bus event.
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// WM8731-style I2C write target: address byte, then 16-bit {reg_addr, data} frames.
// Latency: o_valid in the cycle after the synchronised SCL rise of the frame's last bit.
// Backpressure: none (NACK only on errors); I2C_TGT_REG_CHECK_EN enables the reg_addr range NACK.
module i2c_target_rx
   import i2c_tgt_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_REG     = 7'h0F
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sclk,
   input  logic       i_sdat,
   output logic       o_sdat_pull,
   output logic       o_valid,
   output logic [6:0] o_reg_addr,
   output logic [8:0] o_reg_data,
   output logic       o_busy,
   output logic       o_err
);

   logic       sda;
   logic       scl_rise;
   logic       scl_fall;
   logic       start;
   logic       stop;

   state_t     state;
   logic [6:0] shift;
   logic [2:0] bit_cnt;
   logic [1:0] byte_cnt;
   logic       ack_held;
   logic [6:0] hi_addr;
   logic       hi_d8;
   logic [7:0] rx_byte;
   logic       reg_ok;

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .sclk     (i_sclk),
      .sdat     (i_sdat),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   // The complete byte, valid in the cycle its 8th bit is sampled.
   assign rx_byte = {shift, sda};

`ifdef I2C_TGT_REG_CHECK_EN
   assign reg_ok = (rx_byte[7:1] <= MAX_REG);
`else
   // Range check disabled: every register address is accepted.
   assign reg_ok = 1'b1 | (rx_byte[7:1] <= MAX_REG);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         shift       <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         ack_held    <= 1'b0;
         hi_addr     <= '0;
         hi_d8       <= 1'b0;
         o_sdat_pull <= 1'b0;
         o_valid     <= 1'b0;
         o_reg_addr  <= '0;
         o_reg_data  <= '0;
         o_busy      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         if (start) begin
            // Repeated START silently drops any partial frame.
            state       <= ADDR;
            shift       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            ack_held    <= 1'b0;
            o_sdat_pull <= 1'b0;
            o_busy      <= 1'b0;
         end else if (stop) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            ack_held    <= 1'b0;
            o_sdat_pull <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= (byte_cnt == 2'd1);
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
                           state  <= ADDR_ACK;
                           o_busy <= 1'b1;
                        end else begin
                           state <= IGNORE;
                           o_err <= (rx_byte[7:1] == DEV_ADDR);
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[5:0], sda};
                     end
                  end
               end
               ADDR_ACK, DATA_ACK: begin
                  // First SCL fall drives ACK, the next one (after the 9th high phase) releases it.
                  if (scl_fall) begin
                     if (!ack_held) begin
                        o_sdat_pull <= 1'b1;
                        ack_held    <= 1'b1;
                     end else begin
                        o_sdat_pull <= 1'b0;
                        ack_held    <= 1'b0;
                        state       <= DATA;
                        o_busy      <= 1'b1;
                     end
                  end
               end
               DATA: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (byte_cnt >= FRAME_BYTES) begin
                           state  <= IGNORE;
                           o_busy <= 1'b0;
                           o_err  <= 1'b1;
                        end else if (byte_cnt == 2'd0) begin
                           if (reg_ok) begin
                              hi_addr  <= rx_byte[7:1];
                              hi_d8    <= rx_byte[0];
                              byte_cnt <= 2'd1;
                              state    <= DATA_ACK;
                           end else begin
                              state  <= IGNORE;
                              o_busy <= 1'b0;
                              o_err  <= 1'b1;
                           end
                        end else begin
                           o_valid    <= 1'b1;
                           o_reg_addr <= hi_addr;
                           o_reg_data <= {hi_d8, rx_byte};
                           byte_cnt   <= 2'd2;
                           state      <= DATA_ACK;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[5:0], sda};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bit-banged I2C master driving i2c_target_rx; o_valid/o_err checked by a queue scoreboard.
module tb_i2c_target_rx;

   localparam int HALF = 8;

   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } frame_t;

   logic       clk;
   logic       rst_n;
   logic       scl_m;
   logic       sda_m;
   logic       sdat;
   logic       sdat_pull;
   logic       valid;
   logic [6:0] reg_addr;
   logic [8:0] reg_data;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   frame_t     exp_frames[$];
   int         exp_errs[$];
   logic [6:0] last_addr;
   logic [8:0] last_data;

   assign sdat = sda_m & ~sdat_pull;

   i2c_target_rx dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_sclk      (scl_m),
      .i_sdat      (sdat),
      .o_sdat_pull (sdat_pull),
      .o_valid     (valid),
      .o_reg_addr  (reg_addr),
      .o_reg_data  (reg_data),
      .o_busy      (busy),
      .o_err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the head of the expectation queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            checks++;
            if (exp_frames.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got addr 0x%0h data 0x%0h, expected no pulse",
                        reg_addr, reg_data);
            end else begin
               frame_t f;
               f = exp_frames.pop_front();
               if (reg_addr !== f.addr || reg_data !== f.data) begin
                  errors++;
                  $display("FAIL frame: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                           reg_addr, reg_data, f.addr, f.data);
               end
            end
         end
         if (err) begin
            checks++;
            if (exp_errs.size() == 0) begin
               errors++;
               $display("FAIL unexpected_err: got o_err=1, expected 0");
            end else begin
               void'(exp_errs.pop_front());
            end
         end
      end
   end

   task automatic wait_half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_half();
      scl_m = 1'b1; wait_half();
      sda_m = 1'b0; wait_half();
      scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_half();
      scl_m = 1'b1; wait_half();
      sda_m = 1'b1; wait_half();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; wait_half();
         scl_m = 1'b1; wait_half();
         scl_m = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
      logic ack;
      send_bits(b, 8);
      sda_m = 1'b1; wait_half();
      scl_m = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      ack = ~sdat;
      repeat (HALF / 2) @(negedge clk);
      scl_m = 1'b0;
      chk(name, {31'd0, ack}, {31'd0, exp_ack});
   endtask

   task automatic push_frame(input logic [6:0] a, input logic [8:0] d);
      frame_t f;
      f.addr = a;
      f.data = d;
      exp_frames.push_back(f);
      last_addr = a;
      last_data = d;
   endtask

   // Bounded drain: anything still queued never appeared on the outputs.
   task automatic end_scn(input string name);
      repeat (4 * HALF) @(negedge clk);
      chk({name, "_missing_valid"}, exp_frames.size(), 0);
      chk({name, "_missing_err"}, exp_errs.size(), 0);
      chk({name, "_busy_idle"}, {31'd0, busy}, 0);
      exp_frames.delete();
      exp_errs.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      last_addr = '0;
      last_data = '0;
      repeat (5) @(negedge clk);
      chk("rst_outputs", {21'd0, sdat_pull, valid, reg_addr, reg_data, busy, err}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Good frame: reg 0x02 <= 0x015.
      push_frame(7'h02, 9'h015);
      bus_start();
      send_byte(8'h34, 1'b1, "s1_addr_ack");
      chk("s1_busy", {31'd0, busy}, 1);
      send_byte(8'h04, 1'b1, "s1_b0_ack");
      send_byte(8'h15, 1'b1, "s1_b1_ack");
      bus_stop();
      end_scn("s1");
      chk("s1_reg_addr_hold", {25'd0, reg_addr}, {25'd0, last_addr});
      chk("s1_reg_data_hold", {23'd0, reg_data}, {23'd0, last_data});

      // Other device address: ignored silently.
      bus_start();
      send_byte(8'h36, 1'b0, "s2_addr_nack");
      send_byte(8'h04, 1'b0, "s2_ignored_nack");
      bus_stop();
      end_scn("s2");

      // Read request to our address: NACK plus error.
      exp_errs.push_back(1);
      bus_start();
      send_byte(8'h35, 1'b0, "s3_read_nack");
      bus_stop();
      end_scn("s3");

      // Third data byte overruns the frame.
      push_frame(7'h0F, 9'h000);
      exp_errs.push_back(1);
      bus_start();
      send_byte(8'h34, 1'b1, "s4_addr_ack");
      send_byte(8'h1E, 1'b1, "s4_b0_ack");
      send_byte(8'h00, 1'b1, "s4_b1_ack");
      send_byte(8'hAA, 1'b0, "s4_b2_nack");
      bus_stop();
      end_scn("s4");

      // Half frame then STOP.
      exp_errs.push_back(1);
      bus_start();
      send_byte(8'h34, 1'b1, "s5_addr_ack");
      send_byte(8'h04, 1'b1, "s5_b0_ack");
      bus_stop();
      end_scn("s5");
      chk("s5_reg_addr_kept", {25'd0, reg_addr}, {25'd0, last_addr});
      chk("s5_reg_data_kept", {23'd0, reg_data}, {23'd0, last_data});

      // Repeated START discards the half frame without an error.
      push_frame(7'h03, 9'h001);
      bus_start();
      send_byte(8'h34, 1'b1, "s6_addr_ack");
      send_byte(8'h04, 1'b1, "s6_b0_ack");
      bus_start();
      send_byte(8'h34, 1'b1, "s6_readdr_ack");
      send_byte(8'h06, 1'b1, "s6_b0b_ack");
      send_byte(8'h01, 1'b1, "s6_b1_ack");
      bus_stop();
      end_scn("s6");

      // Reset mid-byte, then a full frame with data[8] set.
      bus_start();
      send_byte(8'h34, 1'b1, "s7_addr_ack");
      send_bits(8'h04, 4);
      chk("s7_busy_pre_rst", {31'd0, busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("s7_rst_outputs", {21'd0, sdat_pull, valid, reg_addr, reg_data, busy, err}, 0);
      last_addr = '0;
      last_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      push_frame(7'h07, 9'h155);
      bus_start();
      send_byte(8'h34, 1'b1, "s7_addr2_ack");
      send_byte(8'h0F, 1'b1, "s7_b0_ack");
      send_byte(8'h55, 1'b1, "s7_b1_ack");
      bus_stop();
      end_scn("s7");

`ifdef I2C_TGT_REG_CHECK_EN
      // Register 0x11 is beyond the legal range.
      exp_errs.push_back(1);
      bus_start();
      send_byte(8'h34, 1'b1, "s8_addr_ack");
      send_byte(8'h22, 1'b0, "s8_reg_nack");
      bus_stop();
      end_scn("s8");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
